// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the 480x272 TFT panel: counters, data-enable,
// sync strobes, active-pixel coordinates and per-frame pulses, all registered.
module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned V_SYNC   = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  output logic [9:0]  hcnt,
  output logic [9:0]  vcnt,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic        vblank_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PIX_W   = 9;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_TOT   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_TOT   = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_SY_HI = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY_HI = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_DE_LO = CNT_W'(H_SYNC + H_BP + 1);
  localparam logic [CNT_W-1:0] H_DE_HI = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE_LO = CNT_W'(V_SYNC + V_BP + 1);
  localparam logic [CNT_W-1:0] V_DE_HI = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] H_VB    = CNT_W'(H_SYNC + H_BP + H_ACTIVE + 1);
  localparam logic [CNT_W-1:0] V_VB    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic              de_q, de_d;
  logic              hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic [PIX_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic              frame_start_q, frame_start_d;
  logic              vblank_tick_q, vblank_tick_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              run_d;

  // Next counter position, then every output decoded from that same position
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          hcnt_d  = ONE;
          vcnt_d  = ONE;
        end else begin
          hcnt_d = '0;
          vcnt_d = '0;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else if (hcnt_q == H_TOT) begin
          hcnt_d = ONE;
          vcnt_d = (vcnt_q == V_TOT) ? ONE : vcnt_q + ONE;
        end else begin
          hcnt_d = hcnt_q + ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    endcase

    run_d         = (state_d == S_RUN);
    de_d          = run_d && (hcnt_d >= H_DE_LO) && (hcnt_d <= H_DE_HI)
                          && (vcnt_d >= V_DE_LO) && (vcnt_d <= V_DE_HI);
    hsync_n_d     = !(run_d && (hcnt_d >= ONE) && (hcnt_d <= H_SY_HI));
    vsync_n_d     = !(run_d && (vcnt_d >= ONE) && (vcnt_d <= V_SY_HI));
    pix_x_d       = de_d ? PIX_W'(hcnt_d - H_DE_LO) : '0;
    pix_y_d       = de_d ? PIX_W'(vcnt_d - V_DE_LO) : '0;
    frame_start_d = run_d && (hcnt_d == ONE) && (vcnt_d == ONE);
    vblank_tick_d = run_d && (hcnt_d == H_VB) && (vcnt_d == V_VB);
    frame_cnt_d   = frame_cnt_q + FCNT_W'(frame_start_d);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      de_q          <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      vblank_tick_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      de_q          <= de_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      vblank_tick_q <= vblank_tick_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign de          = de_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign vblank_tick = vblank_tick_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
